// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two RAM requesters (CPU port C, host port H),
// the arbiter and the single-write / single-read data RAM.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // Port C (CPU load/store path)
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;

  // Port H (host/debug loader)
  logic              h_req;
  logic              h_we;
  logic              h_lock;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic              h_gnt;
  logic              h_rvalid;
  logic [DATA_W-1:0] h_rdata;

  // RAM side
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  // Arbiter view: requests and RAM read data come in, grants and RAM controls go out
  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  h_req, h_we, h_lock, h_addr, h_wdata,
    input  ram_rdata,
    output c_gnt, c_rvalid, c_rdata,
    output h_gnt, h_rvalid, h_rdata,
    output ram_we, ram_waddr, ram_wdata, ram_raddr
  );

  // Requester/RAM-model view: the mirror image of the arbiter
  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output h_req, h_we, h_lock, h_addr, h_wdata,
    output ram_rdata,
    input  c_gnt, c_rvalid, c_rdata,
    input  h_gnt, h_rvalid, h_rdata,
    input  ram_we, ram_waddr, ram_wdata, ram_raddr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the CPU data RAM. Grants at most one access per cycle
// (round-robin or host-priority), supports host bus locking for atomic bursts,
// and tags the one-cycle-late read data with the port that issued the load.
module mem_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int HOST_PRIORITY = 0
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  // Last winner (0 = C, 1 = H); resets to H so C wins the first conflict
  logic r_last;
  logic r_locked;
  logic r_rdC;
  logic r_rdH;

  logic              w_cGnt;
  logic              w_hGnt;
  logic              w_winWe;
  logic [ADDR_W-1:0] w_winAddr;
  logic [DATA_W-1:0] w_winWdata;

  // Grant decision: lock first, then lone requester, then priority / round-robin.
  // Grants are held off while reset is asserted so the RAM sees no access.
  always_comb begin
    w_cGnt = 1'b0;
    w_hGnt = 1'b0;
    if (!rst) begin
      if (r_locked && bus.h_req) begin
        w_hGnt = 1'b1;
      end else if (bus.c_req && !bus.h_req) begin
        w_cGnt = 1'b1;
      end else if (!bus.c_req && bus.h_req) begin
        w_hGnt = 1'b1;
      end else if (bus.c_req && bus.h_req) begin
        if (HOST_PRIORITY != 0) begin
          w_hGnt = 1'b1;
        end else if (r_last) begin
          w_cGnt = 1'b1;
        end else begin
          w_hGnt = 1'b1;
        end
      end
    end
  end

  // Route the winner's fields to the RAM; everything is zero with no grant
  always_comb begin
    w_winWe    = 1'b0;
    w_winAddr  = '0;
    w_winWdata = '0;
    if (w_cGnt) begin
      w_winWe    = bus.c_we;
      w_winAddr  = bus.c_addr;
      w_winWdata = bus.c_wdata;
    end else if (w_hGnt) begin
      w_winWe    = bus.h_we;
      w_winAddr  = bus.h_addr;
      w_winWdata = bus.h_wdata;
    end
  end

  // Arbitration state: winner pointer, host lock and per-port read tags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last   <= 1'b1;
      r_locked <= 1'b0;
      r_rdC    <= 1'b0;
      r_rdH    <= 1'b0;
    end else begin
      if (w_cGnt) begin
        r_last <= 1'b0;
      end else if (w_hGnt) begin
        r_last <= 1'b1;
      end

      if (!bus.h_req) begin
        r_locked <= 1'b0;
      end else if (w_hGnt) begin
        r_locked <= bus.h_lock;
      end

      r_rdC <= w_cGnt && !bus.c_we;
      r_rdH <= w_hGnt && !bus.h_we;
    end
  end

  assign bus.c_gnt     = w_cGnt;
  assign bus.h_gnt     = w_hGnt;
  assign bus.ram_we    = w_winWe;
  assign bus.ram_waddr = w_winAddr;
  assign bus.ram_wdata = w_winWdata;
  assign bus.ram_raddr = w_winAddr;
  assign bus.c_rvalid  = r_rdC;
  assign bus.h_rvalid  = r_rdH;
  assign bus.c_rdata   = bus.ram_rdata;
  assign bus.h_rdata   = bus.ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: one round-robin and one host-priority instance,
// each with its own behavioural RAM. A vector table covers single-cycle
// behaviour; hand-written sequences cover lock, priority and reset corners.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  typedef struct {
    logic          cReq;
    logic          cWe;
    logic [AW-1:0] cAddr;
    logic [DW-1:0] cWdata;
    logic          hReq;
    logic          hWe;
    logic          hLock;
    logic [AW-1:0] hAddr;
    logic [DW-1:0] hWdata;
    logic          eCGnt;
    logic          eHGnt;
    logic          eCRvalid;
    logic          eHRvalid;
    logic          eRamWe;
    logic [DW-1:0] eRdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preloadEn = 1'b1;
  int   checkCount = 0;
  int   passCount = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifRr ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifHp ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOST_PRIORITY(0)) dutRr (
    .clk(clk), .rst(rst), .bus(ifRr)
  );
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOST_PRIORITY(1)) dutHp (
    .clk(clk), .rst(rst), .bus(ifHp)
  );

  logic [DW-1:0] ram0 [0:65535];
  logic [DW-1:0] ram1 [0:65535];

  // Behavioural RAMs: preload while in reset, otherwise write port plus registered read
  always @(posedge clk) begin
    if (preloadEn) begin
      ram0[16'h0010] <= 16'hBEEF;
      ram0[16'h0011] <= 16'h1111;
      ram0[16'h0012] <= 16'h2222;
      ram0[16'h0200] <= 16'hC0DE;
      ram0[16'h0201] <= 16'hD00D;
      ram1[16'h0010] <= 16'h0000;
    end else begin
      if (ifRr.ram_we) ram0[ifRr.ram_waddr] <= ifRr.ram_wdata;
      if (ifHp.ram_we) ram1[ifHp.ram_waddr] <= ifHp.ram_wdata;
    end
    ifRr.ram_rdata <= ram0[ifRr.ram_raddr];
    ifHp.ram_rdata <= ram1[ifHp.ram_raddr];
  end

  function automatic vec_t mk(
    input logic cReq, input logic cWe, input logic [AW-1:0] cAddr, input logic [DW-1:0] cWdata,
    input logic hReq, input logic hWe, input logic hLock, input logic [AW-1:0] hAddr,
    input logic [DW-1:0] hWdata,
    input logic eCGnt, input logic eHGnt, input logic eCRvalid, input logic eHRvalid,
    input logic eRamWe, input logic [DW-1:0] eRdata);
    vec_t v;
    v.cReq = cReq;   v.cWe = cWe;   v.cAddr = cAddr;   v.cWdata = cWdata;
    v.hReq = hReq;   v.hWe = hWe;   v.hLock = hLock;   v.hAddr = hAddr;
    v.hWdata = hWdata;
    v.eCGnt = eCGnt; v.eHGnt = eHGnt; v.eCRvalid = eCRvalid; v.eHRvalid = eHRvalid;
    v.eRamWe = eRamWe; v.eRdata = eRdata;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    ifRr.c_req   = v.cReq;
    ifRr.c_we    = v.cWe;
    ifRr.c_addr  = v.cAddr;
    ifRr.c_wdata = v.cWdata;
    ifRr.h_req   = v.hReq;
    ifRr.h_we    = v.hWe;
    ifRr.h_lock  = v.hLock;
    ifRr.h_addr  = v.hAddr;
    ifRr.h_wdata = v.hWdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkRrVector(input string tag, input vec_t v);
    checkOutput({tag, ".c_gnt"},    {31'd0, ifRr.c_gnt},    {31'd0, v.eCGnt});
    checkOutput({tag, ".h_gnt"},    {31'd0, ifRr.h_gnt},    {31'd0, v.eHGnt});
    checkOutput({tag, ".c_rvalid"}, {31'd0, ifRr.c_rvalid}, {31'd0, v.eCRvalid});
    checkOutput({tag, ".h_rvalid"}, {31'd0, ifRr.h_rvalid}, {31'd0, v.eHRvalid});
    checkOutput({tag, ".ram_we"},   {31'd0, ifRr.ram_we},   {31'd0, v.eRamWe});
    if (v.eCRvalid)
      checkOutput({tag, ".c_rdata"}, {16'd0, ifRr.c_rdata}, {16'd0, v.eRdata});
    else if (v.eHRvalid)
      checkOutput({tag, ".h_rdata"}, {16'd0, ifRr.h_rdata}, {16'd0, v.eRdata});
    if (!v.eCGnt && !v.eHGnt)
      checkOutput({tag, ".ram_raddr_idle"}, {16'd0, ifRr.ram_raddr}, 32'd0);
  endtask

  task automatic driveHp(input logic cReq, input logic hReq);
    ifHp.c_req   = cReq;
    ifHp.c_we    = 1'b0;
    ifHp.c_addr  = 16'h0010;
    ifHp.c_wdata = '0;
    ifHp.h_req   = hReq;
    ifHp.h_we    = 1'b0;
    ifHp.h_lock  = 1'b0;
    ifHp.h_addr  = 16'h0010;
    ifHp.h_wdata = '0;
  endtask

  vec_t tbl[$];
  vec_t idle;
  vec_t v;

  initial begin
    idle = mk(0,0,16'h0,16'h0, 0,0,0,16'h0,16'h0, 0,0,0,0,0,16'h0);
    applyStimulus(idle);
    driveHp(1'b0, 1'b0);
    ifHp.ram_rdata = '0;
    ifRr.ram_rdata = '0;

    //  C: req we addr wdata | H: req we lock addr wdata | exp cG hG cRv hRv we rdata
    tbl.push_back(mk(1,0,16'h0011,16'h0, 1,0,0,16'h0200,16'h0, 1,0,0,0,0,16'h0));
    tbl.push_back(mk(1,0,16'h0012,16'h0, 1,0,0,16'h0200,16'h0, 0,1,1,0,0,16'h1111));
    tbl.push_back(mk(1,0,16'h0012,16'h0, 1,0,0,16'h0201,16'h0, 1,0,0,1,0,16'hC0DE));
    tbl.push_back(mk(1,0,16'h0010,16'h0, 1,0,0,16'h0201,16'h0, 0,1,1,0,0,16'h2222));
    tbl.push_back(mk(0,0,16'h0,16'h0,    0,0,0,16'h0,16'h0,    0,0,0,1,0,16'hD00D));
    tbl.push_back(mk(0,0,16'h0,16'h0,    0,0,0,16'h0,16'h0,    0,0,0,0,0,16'h0));
    tbl.push_back(mk(1,0,16'h0010,16'h0, 0,0,0,16'h0,16'h0,    1,0,0,0,0,16'h0));
    tbl.push_back(mk(0,0,16'h0,16'h0,    0,0,0,16'h0,16'h0,    0,0,1,0,0,16'hBEEF));
    tbl.push_back(mk(1,1,16'h0020,16'hA5A5, 0,0,0,16'h0,16'h0, 1,0,0,0,1,16'h0));
    tbl.push_back(mk(1,0,16'h0020,16'h0, 0,0,0,16'h0,16'h0,    1,0,0,0,0,16'h0));
    tbl.push_back(mk(1,0,16'h0011,16'h0, 0,0,0,16'h0,16'h0,    1,0,1,0,0,16'hA5A5));
    tbl.push_back(mk(1,0,16'h0012,16'h0, 0,0,0,16'h0,16'h0,    1,0,1,0,0,16'h1111));
    tbl.push_back(mk(0,0,16'h0,16'h0,    0,0,0,16'h0,16'h0,    0,0,1,0,0,16'h2222));
    tbl.push_back(mk(0,0,16'h0,16'h0,    1,1,0,16'h0030,16'h5A5A, 0,1,0,0,1,16'h0));
    tbl.push_back(mk(0,0,16'h0,16'h0,    1,0,0,16'h0030,16'h0, 0,1,0,0,0,16'h0));
    tbl.push_back(mk(0,0,16'h0,16'h0,    0,0,0,16'h0,16'h0,    0,0,0,1,0,16'h5A5A));
    tbl.push_back(mk(1,0,16'h0010,16'h0, 0,0,0,16'h0,16'h0,    1,0,0,0,0,16'h0));
    tbl.push_back(mk(0,0,16'h0,16'h0,    0,0,0,16'h0,16'h0,    0,0,1,0,0,16'hBEEF));

    // Reset with RAM preload, release on a falling edge
    repeat (3) @(posedge clk);
    @(negedge clk);
    preloadEn = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("reset.rr_c_rvalid", {31'd0, ifRr.c_rvalid}, 32'd0);
    checkOutput("reset.rr_h_rvalid", {31'd0, ifRr.h_rvalid}, 32'd0);
    checkOutput("reset.rr_c_gnt",    {31'd0, ifRr.c_gnt},    32'd0);
    checkOutput("reset.rr_h_gnt",    {31'd0, ifRr.h_gnt},    32'd0);
    checkOutput("reset.hp_c_rvalid", {31'd0, ifHp.c_rvalid}, 32'd0);
    checkOutput("reset.hp_h_rvalid", {31'd0, ifHp.h_rvalid}, 32'd0);

    // Table-driven vectors on the round-robin instance, one per cycle
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      applyStimulus(tbl[i]);
      #1;
      checkRrVector($sformatf("vec%0d", i), tbl[i]);
    end

    // Locked host burst: C was last winner, so H wins, then lock keeps it
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      v = mk(1,0,16'h0100,16'h0, 1,1,1,16'h0100,16'h1234, 0,1,0,0,1,16'h0);
      applyStimulus(v);
      #1;
      checkRrVector($sformatf("lock%0d", i), v);
    end
    @(negedge clk);
    v = mk(1,0,16'h0100,16'h0, 0,0,0,16'h0,16'h0, 1,0,0,0,0,16'h0);
    applyStimulus(v);
    #1;
    checkRrVector("lockRelease", v);
    @(negedge clk);
    applyStimulus(idle);
    v = idle;
    v.eCRvalid = 1'b1;
    v.eRdata = 16'h1234;
    #1;
    checkRrVector("lockReadBack", v);

    // Host priority: H wins every conflict, C is served once H drops
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      driveHp(1'b1, 1'b1);
      #1;
      checkOutput($sformatf("hp%0d.h_gnt", i), {31'd0, ifHp.h_gnt}, 32'd1);
      checkOutput($sformatf("hp%0d.c_gnt", i), {31'd0, ifHp.c_gnt}, 32'd0);
    end
    @(negedge clk);
    driveHp(1'b1, 1'b0);
    #1;
    checkOutput("hpRelease.c_gnt", {31'd0, ifHp.c_gnt}, 32'd1);
    checkOutput("hpRelease.h_gnt", {31'd0, ifHp.h_gnt}, 32'd0);
    @(negedge clk);
    driveHp(1'b0, 1'b0);

    // Reset one cycle after a C load is accepted: pending rvalid must vanish
    @(negedge clk);
    v = mk(1,0,16'h0010,16'h0, 0,0,0,16'h0,16'h0, 1,0,0,0,0,16'h0);
    applyStimulus(v);
    #1;
    checkRrVector("rstLoad", v);
    @(posedge clk);
    #2;
    checkOutput("rstPre.c_rvalid", {31'd0, ifRr.c_rvalid}, 32'd1);
    rst = 1'b1;
    applyStimulus(idle);
    #1;
    checkOutput("rstNow.c_rvalid", {31'd0, ifRr.c_rvalid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rstAfter.c_rvalid", {31'd0, ifRr.c_rvalid}, 32'd0);
    @(negedge clk);
    v = mk(1,0,16'h0010,16'h0, 1,0,0,16'h0011,16'h0, 1,0,0,0,0,16'h0);
    applyStimulus(v);
    #1;
    checkRrVector("rstConflict", v);
    @(negedge clk);
    applyStimulus(idle);
    v = idle;
    v.eCRvalid = 1'b1;
    v.eRdata = 16'hBEEF;
    #1;
    checkRrVector("rstConflictRead", v);

    @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
